// File: rtl/fft_bfly_sequencer_if.sv
// fft_bfly_sequencer_if: butterfly op bus
// Carries one x/y address pair plus twiddle index per valid/ready beat.
interface fft_bfly_sequencer_if #(
    parameter int LOG2N = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] addr_x;
    logic [LOG2N-1:0] addr_y;
    logic [LOG2N-2:0] tw_idx;
    logic [3:0]       stage;
    logic             last_in_stage;

    modport master (
        output out_valid,
        output addr_x,
        output addr_y,
        output tw_idx,
        output stage,
        output last_in_stage,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  addr_x,
        input  addr_y,
        input  tw_idx,
        input  stage,
        input  last_in_stage,
        output out_ready
    );
endinterface

// File: rtl/fft_bfly_sequencer.sv
// fft_bfly_sequencer: radix-2 DIT in-place address/twiddle walker
// Issues one butterfly op per handshake, drains between stages.
module fft_bfly_sequencer #(
    parameter int LOG2N     = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    fft_bfly_sequencer_if.master ob
);
    localparam int AW = LOG2N;
    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(DRAIN_CYC + 1) + 1;
    localparam int DL = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    localparam logic [KW-1:0] KMAX  = '1;
    localparam logic [3:0]    SMAX  = 4'(LOG2N - 1);
    localparam logic [DW-1:0] DLAST = DW'(DL);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [AW-1:0] ax;
        logic [AW-1:0] ay;
        logic [KW-1:0] tw;
        logic          last;
    } op_t;

    // Address/twiddle for op k of stage s; x leg has bit s clear.
    function automatic op_t f_op(
        input logic [3:0]    s,
        input logic [KW-1:0] k
    );
        op_t           o;
        logic [AW-1:0] kk;
        logic [AW-1:0] span;
        logic [AW-1:0] msk;
        logic [AW-1:0] pos;
        logic [AW-1:0] grp;
        span   = AW'(1) << s;
        msk    = span - AW'(1);
        kk     = AW'(k);
        pos    = kk & msk;
        grp    = kk >> s;
        o.ax   = (grp << (s + 4'd1)) | pos;
        o.ay   = o.ax + span;
        o.tw   = KW'(pos << (SMAX - s));
        o.last = (k == KMAX);
        return o;
    endfunction

    state_t        state_q;
    logic [3:0]    s_q;
    logic [KW-1:0] k_q;
    logic [DW-1:0] dcnt_q;
    logic          valid_q;
    op_t           op_q;
    logic          busy_q;
    logic          done_q;
    logic          hs;

    assign hs = valid_q & ob.out_ready;

    assign ob.out_valid     = valid_q;
    assign ob.addr_x        = op_q.ax;
    assign ob.addr_y        = op_q.ay;
    assign ob.tw_idx        = op_q.tw;
    assign ob.stage         = s_q;
    assign ob.last_in_stage = op_q.last;
    assign busy             = busy_q;
    assign done             = done_q;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            dcnt_q  <= '0;
            valid_q <= 1'b0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        s_q     <= '0;
                        k_q     <= '0;
                        op_q    <= f_op(4'd0, '0);
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (k_q != KMAX) begin
                            k_q  <= k_q + KW'(1);
                            op_q <= f_op(s_q, k_q + KW'(1));
                        end else if (DRAIN_CYC == 0 && s_q != SMAX) begin
                            s_q  <= s_q + 4'd1;
                            k_q  <= '0;
                            op_q <= f_op(s_q + 4'd1, '0);
                        end else if (DRAIN_CYC == 0) begin
                            state_q <= FIN;
                            valid_q <= 1'b0;
                            op_q    <= '0;
                            k_q     <= '0;
                            s_q     <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                            valid_q <= 1'b0;
                            op_q    <= '0;
                            k_q     <= '0;
                            dcnt_q  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt_q == DLAST) begin
                        dcnt_q <= '0;
                        if (s_q != SMAX) begin
                            state_q <= ISSUE;
                            s_q     <= s_q + 4'd1;
                            valid_q <= 1'b1;
                            op_q    <= f_op(s_q + 4'd1, '0);
                        end else begin
                            state_q <= FIN;
                            s_q     <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// tb_fft_bfly_sequencer: scoreboard bench for the FFT sequencer
// DUT0 is LOG2N=3/DRAIN=2, DUT1 is LOG2N=4/DRAIN=0.
module tb_fft_bfly_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic start1;
    logic busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    fft_bfly_sequencer_if #(.LOG2N(3)) bus0 ();
    fft_bfly_sequencer_if #(.LOG2N(4)) bus1 ();

    fft_bfly_sequencer #(.LOG2N(3), .DRAIN_CYC(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy0),
        .done  (done0),
        .ob    (bus0)
    );

    fft_bfly_sequencer #(.LOG2N(4), .DRAIN_CYC(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .busy  (busy1),
        .done  (done1),
        .ob    (bus1)
    );

    typedef struct {
        int x;
        int y;
        int tw;
        int s;
        bit last;
    } op_e;

    op_e q0[$];
    op_e q1[$];
    int  n_chk = 0;
    int  n_pass = 0;

    // Classic in-place DIT loop nest: groups of 2*span, twiddle j*N/(2*span).
    task automatic push_model(input int lg, input bit which);
        int  n;
        int  span;
        int  idx;
        op_e e;
        n = 1 << lg;
        for (int s = 0; s < lg; s++) begin
            span = 1 << s;
            idx  = 0;
            for (int base = 0; base < n; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    e.x    = base + j;
                    e.y    = base + j + span;
                    e.tw   = j * (n >> (s + 1));
                    e.s    = s;
                    e.last = (idx == n / 2 - 1);
                    idx++;
                    if (which) q1.push_back(e);
                    else q0.push_back(e);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        start1 = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus0.out_valid, busy0, done0} !== 3'b000) begin
            $display("FAIL reset0_ctl got=%b want=000",
                     {bus0.out_valid, busy0, done0});
        end else n_pass++;
        n_chk++;
        if ({bus0.addr_x, bus0.addr_y, bus0.tw_idx,
             bus0.stage, bus0.last_in_stage} !== '0) begin
            $display("FAIL reset0_fields x=%0d y=%0d tw=%0d s=%0d l=%b want 0",
                     bus0.addr_x, bus0.addr_y, bus0.tw_idx,
                     bus0.stage, bus0.last_in_stage);
        end else n_pass++;
        n_chk++;
        if ({bus1.out_valid, busy1, done1, bus1.addr_x, bus1.addr_y,
             bus1.tw_idx, bus1.stage, bus1.last_in_stage} !== '0) begin
            $display("FAIL reset1_all v=%b b=%b d=%b x=%0d want 0",
                     bus1.out_valid, busy1, done1, bus1.addr_x);
        end else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full LOG2N=3 transform with optional stall and ignored starts.
    task automatic run0(input int stall_op, input int stall_len,
                        input bit rep, input int exp_total);
        int         opn;
        int         stall_rem;
        int         gap;
        int         dones;
        int         done_idx;
        bit         held_v;
        logic [2:0] hx, hy;
        logic [1:0] ht;
        op_e        e;
        opn = 0;
        stall_rem = stall_len;
        gap = 0;
        dones = 0;
        done_idx = -1;
        held_v = 1'b0;
        hx = '0; hy = '0; ht = '0;
        push_model(3, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
                n_chk++;
                if ({bus0.out_valid, busy0} !== 2'b11) begin
                    $display("FAIL first_op_latency valid=%b busy=%b want 11",
                             bus0.out_valid, busy0);
                end else n_pass++;
            end
            if (rep && i == 8) start = 1'b1;
            if (rep && i == 9) start = 1'b0;
            if (bus0.out_valid && opn == stall_op && stall_rem > 0) begin
                bus0.out_ready = 1'b0;
                stall_rem--;
            end else begin
                bus0.out_ready = 1'b1;
            end
            if (bus0.out_valid) begin
                if (gap > 0) begin
                    n_chk++;
                    if (gap != 2) begin
                        $display("FAIL stage_gap got=%0d want=2", gap);
                    end else n_pass++;
                    gap = 0;
                end
                if (held_v) begin
                    n_chk++;
                    if (bus0.addr_x !== hx || bus0.addr_y !== hy ||
                        bus0.tw_idx !== ht) begin
                        $display("FAIL stall_stable got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                                 bus0.addr_x, bus0.addr_y, bus0.tw_idx,
                                 hx, hy, ht);
                    end else n_pass++;
                end
                if (bus0.out_ready) begin
                    held_v = 1'b0;
                    n_chk++;
                    if (q0.size() == 0) begin
                        $display("FAIL extra_op got=(%0d,%0d,%0d) want none",
                                 bus0.addr_x, bus0.addr_y, bus0.tw_idx);
                    end else begin
                        e = q0.pop_front();
                        if (bus0.addr_x !== 3'(e.x) ||
                            bus0.addr_y !== 3'(e.y) ||
                            bus0.tw_idx !== 2'(e.tw) ||
                            bus0.stage !== 4'(e.s) ||
                            bus0.last_in_stage !== e.last) begin
                            $display("FAIL op%0d got=(%0d,%0d,%0d,s%0d,l%b) want=(%0d,%0d,%0d,s%0d,l%b)",
                                     opn, bus0.addr_x, bus0.addr_y,
                                     bus0.tw_idx, bus0.stage,
                                     bus0.last_in_stage,
                                     e.x, e.y, e.tw, e.s, e.last);
                        end else n_pass++;
                    end
                    opn++;
                end else begin
                    held_v = 1'b1;
                    hx = bus0.addr_x;
                    hy = bus0.addr_y;
                    ht = bus0.tw_idx;
                end
            end else if (busy0) begin
                gap++;
            end
            if (done0) begin
                dones++;
                done_idx = i;
                n_chk++;
                if (busy0 !== 1'b0) begin
                    $display("FAIL busy_in_fin got=%b want=0", busy0);
                end else n_pass++;
                if (rep) start = 1'b1;
                break;
            end
        end
        n_chk++;
        if (done_idx < 0) begin
            $display("FAIL done_timeout got=none want=pulse");
        end else if (done_idx + 2 != exp_total) begin
            $display("FAIL total_cycles got=%0d want=%0d",
                     done_idx + 2, exp_total);
        end else n_pass++;
        n_chk++;
        if (q0.size() != 0) begin
            $display("FAIL ops_missing got=%0d left want=0", q0.size());
        end else n_pass++;
        q0.delete();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (done0) dones++;
            n_chk++;
            if ({bus0.out_valid, busy0} !== 2'b00) begin
                $display("FAIL idle_after_done valid=%b busy=%b want 00",
                         bus0.out_valid, busy0);
            end else n_pass++;
        end
        n_chk++;
        if (dones != 1) begin
            $display("FAIL done_count got=%0d want=1", dones);
        end else n_pass++;
    endtask

    task automatic test_stream();
        run0(-1, 0, 1'b0, 20);
    endtask

    task automatic test_back_pressure();
        run0(5, 3, 1'b0, 23);
    endtask

    task automatic test_start_ignored();
        run0(-1, 0, 1'b1, 20);
    endtask

    task automatic test_async_reset();
        bit hit;
        hit = 1'b0;
        bus0.out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.out_valid && bus0.stage == 4'd1 &&
                bus0.addr_x == 3'd1) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_chk++;
        if (!hit) begin
            $display("FAIL reach_stage1 got=none want=op(1,3,2)");
        end else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus0.out_valid, busy0, done0, bus0.addr_x, bus0.addr_y,
             bus0.tw_idx, bus0.stage, bus0.last_in_stage} !== '0) begin
            $display("FAIL async_reset v=%b b=%b x=%0d y=%0d tw=%0d s=%0d want 0",
                     bus0.out_valid, busy0, bus0.addr_x, bus0.addr_y,
                     bus0.tw_idx, bus0.stage);
        end else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run0(-1, 0, 1'b0, 20);
    endtask

    task automatic test_radix16();
        int  nvalid;
        int  gaps;
        int  done_idx;
        op_e e;
        nvalid = 0;
        gaps = 0;
        done_idx = -1;
        bus1.out_ready = 1'b1;
        push_model(4, 1'b1);
        start1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (bus1.out_valid) begin
                nvalid++;
                n_chk++;
                if (q1.size() == 0) begin
                    $display("FAIL r16_extra got=(%0d,%0d) want none",
                             bus1.addr_x, bus1.addr_y);
                end else begin
                    e = q1.pop_front();
                    if (bus1.addr_x !== 4'(e.x) ||
                        bus1.addr_y !== 4'(e.y) ||
                        bus1.tw_idx !== 3'(e.tw) ||
                        bus1.stage !== 4'(e.s) ||
                        bus1.last_in_stage !== e.last) begin
                        $display("FAIL r16_op%0d got=(%0d,%0d,%0d,s%0d) want=(%0d,%0d,%0d,s%0d)",
                                 nvalid - 1, bus1.addr_x, bus1.addr_y,
                                 bus1.tw_idx, bus1.stage,
                                 e.x, e.y, e.tw, e.s);
                    end else n_pass++;
                end
                if (bus1.stage == 4'd3) begin
                    n_chk++;
                    if (bus1.addr_y !== bus1.addr_x + 4'd8) begin
                        $display("FAIL r16_s3_span got=%0d want=%0d",
                                 bus1.addr_y, bus1.addr_x + 4'd8);
                    end else n_pass++;
                end
            end else if (nvalid > 0 && nvalid < 32) begin
                gaps++;
            end
            if (done1) begin
                done_idx = i;
                break;
            end
        end
        n_chk++;
        if (gaps != 0 || nvalid != 32) begin
            $display("FAIL r16_stream gaps=%0d valid=%0d want 0/32",
                     gaps, nvalid);
        end else n_pass++;
        n_chk++;
        if (done_idx != 32) begin
            $display("FAIL r16_done_idx got=%0d want=32", done_idx);
        end else n_pass++;
        n_chk++;
        if (q1.size() != 0) begin
            $display("FAIL r16_missing got=%0d want=0", q1.size());
        end else n_pass++;
        q1.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_start_ignored();
        test_async_reset();
        test_radix16();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
